// File: rtl/pipe_reg_file_if.sv
// pipe_reg_file_if: bundles the read, writeback and issue signals of the
// pipelined register file.
//   master : pipeline side. Drives the read addresses, writeback and issue
//            requests, and receives the registered read data and busy flags.
//   slave  : register file side (pipe_reg_file).
interface pipe_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // read ports
  logic              rd_en;
  logic [ADDR_W-1:0] source1;
  logic [ADDR_W-1:0] source2;
  logic [DATA_W-1:0] s1val;
  logic [DATA_W-1:0] s2val;
  logic              s1_busy;
  logic              s2_busy;
  // writeback
  logic              write_enable;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] destVal;
  // issue (marks a register as having an in-flight producer)
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dest;

  modport master (
    output rd_en, source1, source2,
    output write_enable, dest, destVal,
    output issue_en, issue_dest,
    input  s1val, s2val, s1_busy, s2_busy
  );

  modport slave (
    input  rd_en, source1, source2,
    input  write_enable, dest, destVal,
    input  issue_en, issue_dest,
    output s1val, s2val, s1_busy, s2_busy
  );
endinterface

// File: rtl/pipe_reg_file.sv
// pipe_reg_file: 2-read / 1-write register file with registered read ports,
// write-first bypass and a per-register pending (scoreboard) bit.
//   clk     : sole clock, all state updates on the rising edge
//   reset_n : asynchronous active-low reset; clears registers, pending bits
//             and the registered read outputs
//   rf      : pipe_reg_file_if slave modport
//             rd_en/source1/source2 -> s1val/s2val/s1_busy/s2_busy (1 cycle)
//             write_enable/dest/destVal : writeback, clears pending[dest]
//             issue_en/issue_dest       : sets pending[issue_dest]
// With ZERO_REG0=1 register 0 is hard-wired to zero and never pending.
module pipe_reg_file #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  pipe_reg_file_if.slave rf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;

  logic [DATA_W-1:0] s1val_q, s2val_q;
  logic              s1_busy_q, s2_busy_q;

  logic [DATA_W-1:0] rd1_val, rd2_val;
  logic              rd1_busy, rd2_busy;

  logic wr_ok;
  logic iss_ok;
  logic zero1, zero2;
  logic hit1, hit2;

  // Register 0 is filtered out of both the data write and the issue path so
  // it can never hold data or look pending when hard-wired to zero.
  assign wr_ok  = rf.write_enable && !(ZERO_REG0 && (rf.dest == '0));
  assign iss_ok = rf.issue_en && !(ZERO_REG0 && (rf.issue_dest == '0));

  assign zero1 = ZERO_REG0 && (rf.source1 == '0);
  assign zero2 = ZERO_REG0 && (rf.source2 == '0);
  assign hit1  = rf.write_enable && (rf.dest == rf.source1);
  assign hit2  = rf.write_enable && (rf.dest == rf.source2);

  // Read port 1: zero register, then same-edge writeback bypass, then array.
  // A bypassed value is the producer's result, so it is never busy, even if
  // a new issue to the same register lands on this edge.
  always_comb begin
    rd1_val  = regs[rf.source1];
    rd1_busy = pending[rf.source1];
    if (zero1) begin
      rd1_val  = '0;
      rd1_busy = 1'b0;
    end else if (hit1) begin
      rd1_val  = rf.destVal;
      rd1_busy = 1'b0;
    end
  end

  // Read port 2: identical, fully independent of port 1.
  always_comb begin
    rd2_val  = regs[rf.source2];
    rd2_busy = pending[rf.source2];
    if (zero2) begin
      rd2_val  = '0;
      rd2_busy = 1'b0;
    end else if (hit2) begin
      rd2_val  = rf.destVal;
      rd2_busy = 1'b0;
    end
  end

  // Scoreboard update: clear on writeback first, then set on issue, so an
  // issue and a writeback to the same register on one edge leave it pending.
  always_comb begin
    pending_nxt = pending;
    if (rf.write_enable) begin
      pending_nxt[rf.dest] = 1'b0;
    end
    if (iss_ok) begin
      pending_nxt[rf.issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[rf.dest] <= rf.destVal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1val_q   <= '0;
      s2val_q   <= '0;
      s1_busy_q <= 1'b0;
      s2_busy_q <= 1'b0;
    end else if (rf.rd_en) begin
      s1val_q   <= rd1_val;
      s2val_q   <= rd2_val;
      s1_busy_q <= rd1_busy;
      s2_busy_q <= rd2_busy;
    end
  end

  assign rf.s1val   = s1val_q;
  assign rf.s2val   = s2val_q;
  assign rf.s1_busy = s1_busy_q;
  assign rf.s2_busy = s2_busy_q;

endmodule

// File: tb/tb_pipe_reg_file.sv
// tb_pipe_reg_file: scoreboard bench for pipe_reg_file (DATA_W=32, ADDR_W=5,
// ZERO_REG0=1). Each driven cycle pushes the expected registered outputs,
// computed from a behavioural model of the register file, and the entry is
// popped and compared once the DUT has taken the edge.
module tb_pipe_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  typedef struct {
    string       tag;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        b1;
    logic        b2;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  pipe_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pipe_reg_file #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .ZERO_REG0(1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rf     (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_reg [NR];
  bit          m_pend[NR];
  exp_t        last;
  exp_t        sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    last.v1 = '0;
    last.v2 = '0;
    last.b1 = 1'b0;
    last.b2 = 1'b0;
  endfunction

  function automatic void model_read(input int a, input bit we, input int d,
                                     input logic [31:0] v,
                                     output logic [31:0] val, output logic busy);
    if (a == 0) begin
      val  = '0;
      busy = 1'b0;
    end else if (we && d == a) begin
      val  = v;
      busy = 1'b0;
    end else begin
      val  = m_reg[a];
      busy = m_pend[a];
    end
  endfunction

  task automatic idle();
    bus.rd_en        = 1'b0;
    bus.source1      = '0;
    bus.source2      = '0;
    bus.write_enable = 1'b0;
    bus.dest         = '0;
    bus.destVal      = '0;
    bus.issue_en     = 1'b0;
    bus.issue_dest   = '0;
  endtask

  // One clock of stimulus with model update and scoreboard check.
  task automatic step(input string tag, input bit rd, input int s1, input int s2,
                      input bit we, input int d, input logic [31:0] v,
                      input bit iss, input int id);
    exp_t e;
    exp_t g;
    @(negedge clk);
    bus.rd_en        = rd;
    bus.source1      = AW'(s1);
    bus.source2      = AW'(s2);
    bus.write_enable = we;
    bus.dest         = AW'(d);
    bus.destVal      = v;
    bus.issue_en     = iss;
    bus.issue_dest   = AW'(id);
    e = last;
    e.tag = tag;
    if (rd) begin
      model_read(s1, we, d, v, e.v1, e.b1);
      model_read(s2, we, d, v, e.v2, e.b2);
    end
    if (we && d != 0) m_reg[d] = v;
    if (we) m_pend[d] = 1'b0;
    if (iss && id != 0) m_pend[id] = 1'b1;
    sb.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({g.tag, ".s1val"},   bus.s1val,          g.v1);
    chk({g.tag, ".s2val"},   bus.s2val,          g.v2);
    chk({g.tag, ".s1_busy"}, 32'(bus.s1_busy),   32'(g.b1));
    chk({g.tag, ".s2_busy"}, 32'(bus.s2_busy),   32'(g.b2));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".s1val"},   bus.s1val,        32'h0);
    chk({tag, ".s2val"},   bus.s2val,        32'h0);
    chk({tag, ".s1_busy"}, 32'(bus.s1_busy), 32'h0);
    chk({tag, ".s2_busy"}, 32'(bus.s2_busy), 32'h0);
  endtask

  initial begin
    idle();
    model_clear();
    reset_n = 1'b0;
    #3;
    chk_zero_outputs("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // write then read next cycle
    step("wr5",      0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    step("rd5",      1, 5, 0, 0, 0, 32'h0,        0, 0);
    // same-edge bypass on port 2
    step("byp7",     1, 5, 7, 1, 7, 32'h12345678, 0, 0);
    // register 0 is hard-wired
    step("wr0",      0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    step("rd0",      1, 0, 0, 0, 0, 32'h0,        0, 0);
    step("iss0",     1, 0, 0, 0, 0, 32'h0,        1, 0);
    step("rd0b",     1, 0, 0, 1, 0, 32'hA5A5A5A5, 1, 0);
    // scoreboard set/clear/priority on r3
    step("iss3",     0, 0, 0, 0, 0, 32'h0,        1, 3);
    step("rd3busy",  1, 3, 3, 0, 0, 32'h0,        0, 0);
    step("wb3byp",   1, 3, 5, 1, 3, 32'h55,       0, 0);
    step("isswb3",   0, 0, 0, 1, 3, 32'h66,       1, 3);
    step("rd3set",   1, 3, 0, 0, 0, 32'h0,        0, 0);
    // same-edge issue does not make the read busy; the next read is busy
    step("iss9rd",   1, 9, 9, 0, 0, 32'h0,        1, 9);
    step("rd9",      1, 9, 9, 0, 0, 32'h0,        0, 0);
    // rd_en low holds outputs while the source is rewritten
    step("hold_a",   0, 5, 9, 1, 5, 32'hCAFEF00D, 0, 0);
    step("hold_b",   0, 5, 9, 1, 9, 32'h0BADF00D, 0, 0);
    step("hold_rd",  1, 5, 9, 0, 0, 32'h0,        0, 0);
    // top address, full-width compare
    step("wr31",     1, 31, 15, 1, 31, 32'h31313131, 1, 15);
    step("rd31",     1, 15, 31, 0, 0, 32'h0,      0, 0);

    // random traffic over a small address window to force collisions
    for (int n = 0; n < 150; n++) begin
      step("rand",
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 32'($urandom()),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    // mid-operation reset
    step("ld1",      0, 0, 0, 1, 1, 32'h11, 0, 0);
    step("ld2",      0, 0, 0, 1, 2, 32'h22, 0, 0);
    step("ld3",      0, 0, 0, 1, 3, 32'h33, 0, 0);
    step("ld4iss2",  1, 1, 4, 1, 4, 32'h44, 1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("rst_async");
    model_clear();
    @(negedge clk);
    bus.rd_en        = 1'b1;
    bus.source1      = AW'(1);
    bus.source2      = AW'(2);
    bus.write_enable = 1'b1;
    bus.dest         = AW'(1);
    bus.destVal      = 32'hBAD0BAD0;
    bus.issue_en     = 1'b1;
    bus.issue_dest   = AW'(2);
    @(posedge clk);
    #1;
    chk_zero_outputs("rst_hold");
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    step("post_r2",  1, 2, 1, 0, 0, 32'h0, 0, 0);
    step("post_r4",  1, 4, 3, 0, 0, 32'h0, 0, 0);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
